vgaconsole_glyph_seq: RTL
=========================

VGACONSOLE_GLYPH_SEQ -- requirements
Module: vgaconsole_glyph_seq

Interface
REQ-001 SHALL have parameter COLS, default 10: character cells per text line, range 1..42.
REQ-002 SHALL have parameter ROW_BITS, default 3: width of the glyph row select.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_line  input  1  one-cycle request to render one glyph row across COLS cells.
REQ-006 SHALL have port glyph_row  input  ROW_BITS  glyph row 0..6 to render; 7 renders a blank spacing row.
REQ-007 SHALL have port char_valid  input  1  character stream valid.
REQ-008 SHALL have port char_code  input  7  ASCII code of the next cell.
REQ-009 SHALL have port char_ready  output  1  character stream ready.
REQ-010 SHALL have port rom_addr  output  7  registered address to the char ROM, which has 1-cycle registered read latency.
REQ-011 SHALL have port rom_data  input  35  glyph bitmap; row r occupies bits [5r+4:5r], and bit 5r+4 is the leftmost pixel.
REQ-012 SHALL have port pixel  output  1  current pixel value.
REQ-013 SHALL have port pixel_valid  output  1  pixel qualifier.
REQ-014 SHALL have port pixel_x  output  8  line-buffer column of the current pixel.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port line_done  output  1  one-cycle pulse when the last pixel of a line has been emitted.

Function
REQ-017 SHALL implement the states IDLE, REQ, WAIT, LOAD and SHIFT.
REQ-018 IDLE: on start_line, SHALL latch glyph_row, clear col_cnt and pixel_x, and go to REQ; otherwise remain in IDLE.
REQ-019 start_line asserted in any state other than IDLE SHALL be ignored.
REQ-020 REQ: char_ready SHALL be 1 only in this state; on char_valid&&char_ready, SHALL register rom_addr<=char_code and go to WAIT; otherwise hold in REQ indefinitely.
REQ-021 WAIT: one cycle while the ROM samples rom_addr; then go to LOAD.
REQ-022 LOAD: SHALL capture the 6-bit shift register as {rom_data[5r+4:5r], 1'b0} for latched row r<7, or 6'b0 for r=7; then go to SHIFT with pix_cnt=0.
REQ-023 SHIFT: pixel_valid=1 and pixel=shift[5]; each cycle SHALL shift left, increment pix_cnt and increment pixel_x.
REQ-024 SHIFT, pix_cnt==5: if col_cnt==COLS-1, SHALL pulse line_done in the same cycle and go to IDLE; otherwise col_cnt++ and go to REQ.
REQ-025 Cell timing: handshake at edge A; pixels valid for the 6 cycles following edge A+2 (5 glyph pixels plus 1 zero gap); minimum cell period 9 cycles.
REQ-026 pixel_x SHALL equal 6*col+pix within a line and range 0..6*COLS-1; it SHALL NOT wrap within a line.
REQ-027 rom_addr SHALL pass all 7-bit codes unmodified; blanking of non-printable codes is the ROM's responsibility.
REQ-028 rom_addr SHALL hold its value outside REQ handshakes.
REQ-029 char_valid stalls in REQ SHALL NOT alter pixel_x, col_cnt or the latched row.
REQ-030 pixel and pixel_valid SHALL be 0 outside SHIFT.
REQ-031 line_done SHALL be 0 outside the final SHIFT cycle.

Reset
REQ-032 rst SHALL, at the next clock edge, force IDLE and clear the following outputs and registers: char_ready=0, pixel_valid=0, pixel=0, pixel_x=0, busy=0, line_done=0, rom_addr=0, col_cnt=0, pix_cnt=0, shift=0.
REQ-033 rst SHALL take priority over all inputs, including start_line in the same cycle.
REQ-034 rst asserted mid-line SHALL abort the line without a line_done pulse; after rst is released, the block SHALL accept a new start_line.

Verification
REQ-035 COLS=2, row=0, ROM model returns row0=5'b10101 for 0x41, handshake with no stall -> pixels 1,0,1,0,1,0 at x=0..5 then again at x=6..11; rom_addr=0x41; line_done coincides with x=11; total 18 cycles from the first handshake.
REQ-036 row=7 with any codes -> 6*COLS pixels, all 0; every char still consumed (COLS handshakes); line_done pulses once.
REQ-037 char_valid held low 5 cycles in REQ of cell 1 -> char_ready stays high; pixel_valid stays low; pixel_x holds at 6; output after the stall is identical to the no-stall case.
REQ-038 start_line pulsed during SHIFT of cell 0 -> ignored; exactly COLS cells are rendered; only one line_done.
REQ-039 rst asserted in SHIFT at x=3 -> the next cycle has busy=0, pixel_valid=0, pixel_x=0 and no line_done; a new start_line renders correctly from x=0.
REQ-040 row=6, code 0x7F with rom_data=35'h7C0000000 -> pixels 1,1,1,1,1,0.

Source files
------------

// File: rtl/vgaconsole_glyph_seq.sv
// Text-console glyph sequencer: fetches one glyph row per character cell
// from a registered char ROM and serialises it as 5 pixels plus 1 gap.
module vgaconsole_glyph_seq #(
    parameter int COLS     = 10,
    parameter int ROW_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_line,
    input  logic [ROW_BITS-1:0] glyph_row,
    input  logic                char_valid,
    input  logic [6:0]          char_code,
    output logic                char_ready,
    output logic [6:0]          rom_addr,
    input  logic [34:0]         rom_data,
    output logic                pixel,
    output logic                pixel_valid,
    output logic [7:0]          pixel_x,
    output logic                busy,
    output logic                line_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ROW_BITS-1:0] row_q;
    logic [5:0]          col_cnt;
    logic [2:0]          pix_cnt;
    logic [5:0]          shift;
    logic [4:0]          glyph_bits;
    logic                last_pix;
    logic                last_col;

    assign last_pix = (pix_cnt == 3'd5);
    assign last_col = (col_cnt == 6'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        char_ready  = 1'b0;
        pixel_valid = 1'b0;
        pixel       = 1'b0;
        line_done   = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_line) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                pixel_valid = 1'b1;
                pixel       = shift[5];
                if (last_pix) begin
                    if (last_col) begin
                        line_done = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx = S_REQ;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Rows 0..6 select a 5-bit slice; any other row value is a blank row.
    always_comb begin
        glyph_bits = 5'b0;
        for (int r = 0; r < 7; r++) begin
            if (int'(row_q) == r) begin
                glyph_bits = rom_data[5*r +: 5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            col_cnt  <= 6'd0;
            pix_cnt  <= 3'd0;
            shift    <= 6'd0;
            pixel_x  <= 8'd0;
            rom_addr <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_line) begin
                        row_q   <= glyph_row;
                        col_cnt <= 6'd0;
                        pixel_x <= 8'd0;
                    end
                end
                S_REQ: begin
                    if (char_valid) begin
                        rom_addr <= char_code;
                    end
                end
                S_LOAD: begin
                    shift   <= {glyph_bits, 1'b0};
                    pix_cnt <= 3'd0;
                end
                S_SHIFT: begin
                    shift   <= {shift[4:0], 1'b0};
                    pix_cnt <= pix_cnt + 3'd1;
                    pixel_x <= pixel_x + 8'd1;
                    if (last_pix && !last_col) begin
                        col_cnt <= col_cnt + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
